// File: rtl/lcd_cmd_arbiter.sv
// Round-robin arbiter that shares one LCD controller command port between N_REQ requesters.
// Issues one latched command per grant, waits out controller busy, and times out missing acks.
module lcd_cmd_arbiter #(
  parameter int unsigned N_REQ  = 2,
  parameter int unsigned BUS_W  = 10,
  parameter int unsigned TO_CYC = 16
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic [N_REQ-1:0]       req_i,
  input  logic [N_REQ*BUS_W-1:0] cmd_i,
  output logic [N_REQ-1:0]       grant_o,
  output logic [N_REQ-1:0]       done_o,
  output logic                   err_o,
  input  logic                   lcd_busy_i,
  output logic                   lcd_enable_o,
  output logic [BUS_W-1:0]       lcd_bus_o
);

  localparam int unsigned PtrW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int unsigned CntW = $clog2(TO_CYC + 1);
  localparam logic [CntW-1:0] CntLast = CntW'(TO_CYC - 1);
  localparam logic [CntW-1:0] CntMax  = '1;
  localparam logic [PtrW-1:0] PtrLast = PtrW'(N_REQ - 1);

  typedef enum logic [1:0] {StIdle, StIssue, StWaitDone} state_e;

  state_e            state_q;
  logic [N_REQ-1:0]  grant_q;
  logic [N_REQ-1:0]  done_q;
  logic              err_q;
  logic              lcd_enable_q;
  logic [BUS_W-1:0]  lcd_bus_q;
  logic [PtrW-1:0]   ptr_q;
  logic [PtrW-1:0]   owner_q;
  logic [CntW-1:0]   cnt_q;

  logic              pick_valid;
  logic [PtrW-1:0]   pick_idx;
  logic [PtrW-1:0]   scan_idx;
  logic [N_REQ-1:0]  pick_onehot;
  logic [BUS_W-1:0]  pick_cmd;
  logic [PtrW-1:0]   ptr_next;

  // Scan requesters starting at ptr_q, wrapping, and take the first one pending.
  always_comb begin
    pick_valid = 1'b0;
    pick_idx   = '0;
    scan_idx   = '0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      scan_idx = PtrW'((32'(ptr_q) + k) % N_REQ);
      if (!pick_valid && req_i[scan_idx]) begin
        pick_valid = 1'b1;
        pick_idx   = scan_idx;
      end
    end
  end

  always_comb begin
    pick_onehot = '0;
    pick_cmd    = '0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      if (pick_idx == PtrW'(k)) begin
        pick_onehot[k] = 1'b1;
        pick_cmd       = cmd_i[k*BUS_W +: BUS_W];
      end
    end
  end

  assign ptr_next = (owner_q == PtrLast) ? '0 : owner_q + PtrW'(1);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= StIdle;
      grant_q      <= '0;
      done_q       <= '0;
      err_q        <= 1'b0;
      lcd_enable_q <= 1'b0;
      lcd_bus_q    <= '0;
      ptr_q        <= '0;
      owner_q      <= '0;
      cnt_q        <= '0;
    end else begin
      done_q <= '0;
      err_q  <= 1'b0;
      case (state_q)
        StIdle: begin
          // Controller busy also covers its power-up initialisation.
          if (!lcd_busy_i && pick_valid) begin
            grant_q      <= pick_onehot;
            owner_q      <= pick_idx;
            lcd_bus_q    <= pick_cmd;
            lcd_enable_q <= 1'b1;
            cnt_q        <= '0;
            state_q      <= StIssue;
          end
        end
        StIssue: begin
          if (lcd_busy_i) begin
            lcd_enable_q <= 1'b0;
            lcd_bus_q    <= '0;
            state_q      <= StWaitDone;
          end else if (cnt_q == CntLast) begin
            lcd_enable_q <= 1'b0;
            lcd_bus_q    <= '0;
            done_q       <= grant_q;
            err_q        <= 1'b1;
            grant_q      <= '0;
            ptr_q        <= ptr_next;
            state_q      <= StIdle;
          end else if (cnt_q != CntMax) begin
            cnt_q <= cnt_q + CntW'(1);
          end
        end
        StWaitDone: begin
          if (!lcd_busy_i) begin
            done_q  <= grant_q;
            grant_q <= '0;
            ptr_q   <= ptr_next;
            state_q <= StIdle;
          end
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign grant_o      = grant_q;
  assign done_o       = done_q;
  assign err_o        = err_q;
  assign lcd_enable_o = lcd_enable_q;
  assign lcd_bus_o    = lcd_bus_q;

endmodule

// File: tb/tb_lcd_cmd_arbiter.sv
// Directed bench for lcd_cmd_arbiter: reset, init wait, single transfer, round robin,
// timeout, mid-transfer reset and command latching.
module tb_lcd_cmd_arbiter;

  localparam int unsigned N_REQ  = 2;
  localparam int unsigned BUS_W  = 10;
  localparam int unsigned TO_CYC = 16;

  logic                   clk = 1'b0;
  logic                   rst;
  logic [N_REQ-1:0]       req;
  logic [N_REQ*BUS_W-1:0] cmd;
  logic [N_REQ-1:0]       grant;
  logic [N_REQ-1:0]       done;
  logic                   err;
  logic                   lcd_busy;
  logic                   lcd_enable;
  logic [BUS_W-1:0]       lcd_bus;

  int checks = 0;
  int errors = 0;

  lcd_cmd_arbiter #(
    .N_REQ (N_REQ),
    .BUS_W (BUS_W),
    .TO_CYC(TO_CYC)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .req_i       (req),
    .cmd_i       (cmd),
    .grant_o     (grant),
    .done_o      (done),
    .err_o       (err),
    .lcd_busy_i  (lcd_busy),
    .lcd_enable_o(lcd_enable),
    .lcd_bus_o   (lcd_bus)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  task automatic wait_en(input int max_cyc, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max_cyc; i++) begin
      if (lcd_enable === 1'b1) begin
        ok = 1'b1;
        break;
      end
      step();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; req = '0; cmd = '0; lcd_busy = 1'b0;
    step();
    step();
    checks++; if (grant !== 2'b00) begin errors++; $display("FAIL reset_grant: got %b want 00", grant); end
    checks++; if (done !== 2'b00) begin errors++; $display("FAIL reset_done: got %b want 00", done); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b want 0", err); end
    checks++; if (lcd_enable !== 1'b0) begin errors++; $display("FAIL reset_en: got %b want 0", lcd_enable); end
    checks++; if (lcd_bus !== 10'h000) begin errors++; $display("FAIL reset_bus: got %h want 000", lcd_bus); end
    rst = 1'b0;
  endtask

  task automatic test_busy_init();
    bit bad;
    lcd_busy = 1'b1; req = 2'b00; cmd[9:0] = 10'h241;
    do_reset();
    req = 2'b01;
    bad = 1'b0;
    for (int i = 0; i < 950; i++) begin
      step();
      if (grant !== 2'b00 || lcd_enable !== 1'b0) bad = 1'b1;
    end
    checks++; if (bad) begin errors++; $display("FAIL init_hold: got grant %b en %b want 00/0", grant, lcd_enable); end
    lcd_busy = 1'b0;
    step();
    checks++; if (grant !== 2'b01) begin errors++; $display("FAIL init_grant: got %b want 01", grant); end
    checks++; if (lcd_enable !== 1'b1) begin errors++; $display("FAIL init_en: got %b want 1", lcd_enable); end
    checks++; if (lcd_bus !== 10'h241) begin errors++; $display("FAIL init_bus: got %h want 241", lcd_bus); end
    req = 2'b00;
    do_reset();
  endtask

  task automatic test_single_req();
    bit ok;
    bit bad;
    lcd_busy = 1'b0; req = 2'b00; cmd[9:0] = 10'h155;
    do_reset();
    req = 2'b01;
    wait_en(5, ok);
    checks++; if (!ok) begin errors++; $display("FAIL single_wait_en: got en %b want 1", lcd_enable); end
    checks++; if (grant !== 2'b01 || lcd_bus !== 10'h155) begin
      errors++; $display("FAIL single_issue: got grant %b bus %h want 01/155", grant, lcd_bus);
    end
    lcd_busy = 1'b1;
    step();
    checks++; if (lcd_enable !== 1'b0 || lcd_bus !== 10'h000) begin
      errors++; $display("FAIL single_en_drop: got en %b bus %h want 0/000", lcd_enable, lcd_bus);
    end
    checks++; if (grant !== 2'b01) begin errors++; $display("FAIL single_grant_hold: got %b want 01", grant); end
    bad = 1'b0;
    for (int i = 0; i < 50; i++) begin
      step();
      if (done !== 2'b00 || lcd_enable !== 1'b0 || grant !== 2'b01) bad = 1'b1;
    end
    checks++; if (bad) begin errors++; $display("FAIL single_busy_wait: got done %b en %b want 00/0", done, lcd_enable); end
    lcd_busy = 1'b0;
    step();
    checks++; if (done !== 2'b01 || err !== 1'b0 || grant !== 2'b00) begin
      errors++; $display("FAIL single_done: got done %b err %b grant %b want 01/0/00", done, err, grant);
    end
    req = 2'b00;
    step();
    checks++; if (done !== 2'b00) begin errors++; $display("FAIL single_done_pulse: got %b want 00", done); end
  endtask

  task automatic test_round_robin();
    bit ok;
    logic [1:0] exp_g [4];
    logic [9:0] exp_b [4];
    exp_g[0] = 2'b01; exp_g[1] = 2'b10; exp_g[2] = 2'b01; exp_g[3] = 2'b10;
    exp_b[0] = 10'h041; exp_b[1] = 10'h2A5; exp_b[2] = 10'h041; exp_b[3] = 10'h2A5;
    lcd_busy = 1'b0; req = 2'b00; cmd[9:0] = 10'h041; cmd[19:10] = 10'h2A5;
    do_reset();
    req = 2'b11;
    for (int i = 0; i < 4; i++) begin
      wait_en(6, ok);
      checks++; if (!ok || grant !== exp_g[i] || lcd_bus !== exp_b[i]) begin
        errors++;
        $display("FAIL rr_issue_%0d: got en %b grant %b bus %h want 1/%b/%h",
                 i, lcd_enable, grant, lcd_bus, exp_g[i], exp_b[i]);
      end
      lcd_busy = 1'b1;
      step();
      repeat (3) step();
      lcd_busy = 1'b0;
      step();
      if (i == 3) req = 2'b00;
      checks++; if (done !== exp_g[i] || grant !== 2'b00) begin
        errors++; $display("FAIL rr_done_%0d: got done %b grant %b want %b/00", i, done, grant, exp_g[i]);
      end
    end
    step();
    checks++; if (grant !== 2'b00 || lcd_enable !== 1'b0) begin
      errors++; $display("FAIL rr_idle: got grant %b en %b want 00/0", grant, lcd_enable);
    end
  endtask

  task automatic test_timeout();
    bit ok;
    int n;
    lcd_busy = 1'b0; req = 2'b00; cmd[9:0] = 10'h0AA;
    do_reset();
    req = 2'b01;
    wait_en(5, ok);
    checks++; if (!ok) begin errors++; $display("FAIL to_wait_en: got en %b want 1", lcd_enable); end
    n = 0;
    while (lcd_enable === 1'b1 && n < 40) begin
      n++;
      step();
    end
    checks++; if (n != 16) begin errors++; $display("FAIL to_en_len: got %0d cycles want 16", n); end
    checks++; if (done !== 2'b01 || err !== 1'b1 || grant !== 2'b00) begin
      errors++; $display("FAIL to_pulse: got done %b err %b grant %b want 01/1/00", done, err, grant);
    end
    req = 2'b11;
    step();
    checks++; if (done !== 2'b00 || err !== 1'b0) begin
      errors++; $display("FAIL to_pulse_end: got done %b err %b want 00/0", done, err);
    end
    checks++; if (grant !== 2'b10) begin errors++; $display("FAIL to_ptr: got grant %b want 10", grant); end
    req = 2'b00;
    do_reset();
  endtask

  task automatic test_reset_mid();
    bit ok;
    lcd_busy = 1'b0; req = 2'b00; cmd[9:0] = 10'h041; cmd[19:10] = 10'h2A5;
    do_reset();
    req = 2'b11;
    wait_en(5, ok);
    checks++; if (!ok || grant !== 2'b01) begin errors++; $display("FAIL mid_first: got grant %b want 01", grant); end
    lcd_busy = 1'b1;
    step();
    repeat (2) step();
    lcd_busy = 1'b0;
    step();
    wait_en(5, ok);
    checks++; if (!ok || grant !== 2'b10) begin errors++; $display("FAIL mid_second: got grant %b want 10", grant); end
    lcd_busy = 1'b1;
    step();
    step();
    checks++; if (grant !== 2'b10 || lcd_enable !== 1'b0) begin
      errors++; $display("FAIL mid_wait_hold: got grant %b en %b want 10/0", grant, lcd_enable);
    end
    rst = 1'b1; lcd_busy = 1'b0;
    step();
    rst = 1'b0;
    checks++; if (grant !== 2'b00 || done !== 2'b00 || err !== 1'b0 || lcd_enable !== 1'b0 || lcd_bus !== 10'h000) begin
      errors++;
      $display("FAIL mid_abort: got grant %b done %b err %b en %b bus %h want all 0",
               grant, done, err, lcd_enable, lcd_bus);
    end
    step();
    checks++; if (grant !== 2'b01 || lcd_enable !== 1'b1 || lcd_bus !== 10'h041) begin
      errors++; $display("FAIL mid_regrant: got grant %b en %b bus %h want 01/1/041", grant, lcd_enable, lcd_bus);
    end
    req = 2'b00;
    do_reset();
  endtask

  task automatic test_cmd_hold();
    bit ok;
    lcd_busy = 1'b0; req = 2'b00; cmd[9:0] = 10'h241;
    do_reset();
    req = 2'b01;
    wait_en(5, ok);
    checks++; if (!ok || lcd_bus !== 10'h241) begin errors++; $display("FAIL hold_issue: got bus %h want 241", lcd_bus); end
    cmd[9:0] = 10'h3FF;
    step();
    checks++; if (lcd_enable !== 1'b1 || lcd_bus !== 10'h241) begin
      errors++; $display("FAIL hold_cmd_change: got en %b bus %h want 1/241", lcd_enable, lcd_bus);
    end
    req = 2'b00;
    step();
    checks++; if (lcd_enable !== 1'b1 || lcd_bus !== 10'h241 || grant !== 2'b01) begin
      errors++; $display("FAIL hold_req_drop: got en %b bus %h grant %b want 1/241/01", lcd_enable, lcd_bus, grant);
    end
    do_reset();
  endtask

  initial begin
    test_reset();
    test_busy_init();
    test_single_req();
    test_round_robin();
    test_timeout();
    test_reset_mid();
    test_cmd_hold();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
